// File: rtl/cfg_delay_line_if.sv
// Bus bundle for cfg_delay_line: stream input, stage/tap controls, and the
// tapped/last/occupancy outputs. Clock and reset stay outside the bundle.
interface cfg_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic [SELW-1:0]  tap_sel;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [WIDTH-1:0] last_dout;
  logic             last_vld;
  logic [SELW-1:0]  occ;

  // Driver side: pushes beats and picks the tap.
  modport master (
    output en, flush, din, din_vld, tap_sel,
    input  dout, dout_vld, last_dout, last_vld, occ
  );

  // Delay line side.
  modport slave (
    input  en, flush, din, din_vld, tap_sel,
    output dout, dout_vld, last_dout, last_vld, occ
  );
endinterface

// File: rtl/cfg_delay_line.sv
// Configurable delay line: DEPTH {vld,data} stages with a global stall,
// synchronous flush, runtime output tap and a live count of valid stages.

// One pipeline stage. Holds unless shifted; clr wins over shift.
module cfg_delay_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);
  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d,  vld_q;

  // Next stage content: clear, load from upstream, or hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = RST_VAL;
      vld_d  = 1'b0;
    end else if (shift) begin
      data_d = d_in;
      vld_d  = v_in;
    end
  end

  // Stage register with async clear to the idle value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_out = data_q;
  assign v_out = vld_q;
endmodule

module cfg_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rstn,
  cfg_delay_line_if.slave    bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  // Index 0 is the live input; index k is the output of stage k.
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            vld_pipe;
  logic                      shift;
  logic [SELW-1:0]           eff_sel;
  logic [SELW-1:0]           occ_d, occ_q;

  assign dat_pipe[0] = bus.din;
  assign vld_pipe[0] = bus.din_vld;
  assign shift       = bus.en & ~bus.flush;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stg
    cfg_delay_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stg (
      .clk   (clk),
      .rstn  (rstn),
      .shift (shift),
      .clr   (bus.flush),
      .d_in  (dat_pipe[k-1]),
      .v_in  (vld_pipe[k-1]),
      .d_out (dat_pipe[k]),
      .v_out (vld_pipe[k])
    );
  end

  // Out-of-range taps (0 or >DEPTH) fall back to the last stage.
  always_comb begin
    eff_sel = SELW'(DEPTH);
    if (bus.tap_sel != '0 && bus.tap_sel <= SELW'(DEPTH))
      eff_sel = bus.tap_sel;
  end

  // Occupancy tracks beats entering minus the beat leaving the last stage;
  // full-in while full-out keeps it at DEPTH, so it cannot wrap.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush)
      occ_d = '0;
    else if (bus.en)
      occ_d = occ_q + SELW'(vld_pipe[0]) - SELW'(vld_pipe[DEPTH]);
  end

  // Occupancy counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  // Outputs come only from registered stages, never from din.
  assign bus.dout      = dat_pipe[eff_sel];
  assign bus.dout_vld  = vld_pipe[eff_sel];
  assign bus.last_dout = dat_pipe[DEPTH];
  assign bus.last_vld  = vld_pipe[DEPTH];
  assign bus.occ       = occ_q;
endmodule
